// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control FSM: states, opcodes,
// opcode classes, datapath select codes and the bundled control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        LDWB   = 4'd5,
        EXECR  = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        HALT   = 4'd9
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_STORE   = 3'd1,
        CLS_RTYPE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ILLEGAL = 3'd4
    } op_class_t;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_retired;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: buckets a 7-bit RV32 opcode into the
// instruction classes the control FSM understands.
module opcode_class_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    // Exact-match decode; anything unrecognised is illegal.
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_RTYPE:  op_class = CLS_RTYPE;
            OP_BRANCH: op_class = CLS_BRANCH;
            default:   op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM sequencing a shared ALU and unified memory.
// Define MULTICYCLE_MEM_HANDSHAKE_EN to add the mem_ready wait handshake.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_retired,
    output logic       halted,
    output logic [3:0] state_o
);

    state_t    state_r;
    state_t    next_s;
    logic [6:0] op_q_r;
    op_class_t dec_cls_s;
    op_class_t opq_cls_s;
    logic      ready_s;
    ctrl_t     ctrl_s;
    ctrl_t     ctrl_out_s;

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    assign ready_s = mem_ready;
`else
    assign ready_s = 1'b1;
`endif

    opcode_class_dec u_dec_live (
        .opcode   (opcode),
        .op_class (dec_cls_s)
    );

    opcode_class_dec u_dec_held (
        .opcode   (op_q_r),
        .op_class (opq_cls_s)
    );

    // State register and opcode latch captured during DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            op_q_r  <= 7'd0;
        end else begin
            state_r <= next_s;
            if (state_r == DECODE) begin
                op_q_r <= opcode;
            end
        end
    end

    // Next-state logic; memory states stall until the handshake completes.
    always_comb begin
        next_s = state_r;
        case (state_r)
            FETCH:  next_s = ready_s ? DECODE : FETCH;
            DECODE: begin
                case (dec_cls_s)
                    CLS_LOAD, CLS_STORE: next_s = MEMADR;
                    CLS_RTYPE:           next_s = EXECR;
                    CLS_BRANCH:          next_s = BRANCH;
                    default:             next_s = HALT;
                endcase
            end
            MEMADR: begin
                case (opq_cls_s)
                    CLS_LOAD:  next_s = MEMRD;
                    CLS_STORE: next_s = MEMWR;
                    default:   next_s = HALT;
                endcase
            end
            MEMRD:  next_s = ready_s ? LDWB : MEMRD;
            MEMWR:  next_s = ready_s ? FETCH : MEMWR;
            LDWB:   next_s = FETCH;
            EXECR:  next_s = RWB;
            RWB:    next_s = FETCH;
            BRANCH: next_s = FETCH;
            HALT:   next_s = HALT;
            default: next_s = HALT;
        endcase
    end

    // Moore control decode; BRANCH pc_write follows zero, memory strobes gate on ready.
    always_comb begin
        ctrl_s = {$bits(ctrl_t){1'b0}};
        case (state_r)
            FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.iord      = 1'b0;
                ctrl_s.ir_write  = ready_s;
                ctrl_s.alu_src_a = SRC_A_PC;
                ctrl_s.alu_src_b = SRC_B_FOUR;
                ctrl_s.alu_op    = ALU_ADD;
                ctrl_s.pc_write  = ready_s;
                ctrl_s.pc_src    = PC_SRC_ALU;
            end
            DECODE: begin
                ctrl_s.alu_src_a = SRC_A_OLDPC;
                ctrl_s.alu_src_b = SRC_B_IMM;
                ctrl_s.alu_op    = ALU_ADD;
            end
            MEMADR: begin
                ctrl_s.alu_src_a = SRC_A_RS1;
                ctrl_s.alu_src_b = SRC_B_IMM;
                ctrl_s.alu_op    = ALU_ADD;
            end
            MEMRD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            MEMWR: begin
                ctrl_s.mem_write     = 1'b1;
                ctrl_s.iord          = 1'b1;
                ctrl_s.instr_retired = ready_s;
            end
            LDWB: begin
                ctrl_s.reg_write     = 1'b1;
                ctrl_s.mem_to_reg    = 1'b1;
                ctrl_s.instr_retired = 1'b1;
            end
            EXECR: begin
                ctrl_s.alu_src_a = SRC_A_RS1;
                ctrl_s.alu_src_b = SRC_B_RS2;
                ctrl_s.alu_op    = ALU_FUNCT;
            end
            RWB: begin
                ctrl_s.reg_write     = 1'b1;
                ctrl_s.mem_to_reg    = 1'b0;
                ctrl_s.instr_retired = 1'b1;
            end
            BRANCH: begin
                ctrl_s.alu_src_a     = SRC_A_RS1;
                ctrl_s.alu_src_b     = SRC_B_RS2;
                ctrl_s.alu_op        = ALU_SUB;
                ctrl_s.pc_src        = PC_SRC_ALUOUT;
                ctrl_s.pc_write      = zero;
                ctrl_s.instr_retired = 1'b1;
            end
            HALT: begin
                ctrl_s.halted = 1'b1;
            end
            default: begin
                ctrl_s = {$bits(ctrl_t){1'b0}};
            end
        endcase
    end

    // Reset silences every output in the same cycle, not just at the next edge.
    assign ctrl_out_s = reset ? {$bits(ctrl_t){1'b0}} : ctrl_s;

    assign pc_write      = ctrl_out_s.pc_write;
    assign ir_write      = ctrl_out_s.ir_write;
    assign mem_read      = ctrl_out_s.mem_read;
    assign mem_write     = ctrl_out_s.mem_write;
    assign iord          = ctrl_out_s.iord;
    assign alu_src_a     = ctrl_out_s.alu_src_a;
    assign alu_src_b     = ctrl_out_s.alu_src_b;
    assign alu_op        = ctrl_out_s.alu_op;
    assign pc_src        = ctrl_out_s.pc_src;
    assign reg_write     = ctrl_out_s.reg_write;
    assign mem_to_reg    = ctrl_out_s.mem_to_reg;
    assign instr_retired = ctrl_out_s.instr_retired;
    assign halted        = ctrl_out_s.halted;
    assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; per-cycle output vectors
// are hand-written constants. Handshake step runs when MULTICYCLE_MEM_HANDSHAKE_EN is set.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    logic       mem_ready;
`endif
    logic       pc_write, ir_write, mem_read, mem_write, iord;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       pc_src, reg_write, mem_to_reg, instr_retired, halted;
    logic [3:0] state_o;

    int tests_run = 0;
    int tests_failed = 0;
    int retire_cnt = 0;
    int snap;

    // {pc_write, ir_write, mem_read, mem_write, iord, src_a, src_b, alu_op,
    //  pc_src, reg_write, mem_to_reg, instr_retired, halted, state}
    logic [19:0] obs_vec;
    assign obs_vec = {pc_write, ir_write, mem_read, mem_write, iord, alu_src_a, alu_src_b,
                      alu_op, pc_src, reg_write, mem_to_reg, instr_retired, halted, state_o};

    localparam logic [19:0] V_ZERO   = 20'h00000;
    localparam logic [19:0] V_FETCH  = {5'b11100, 2'b00, 2'b01, 2'b00, 5'b00000, 4'd0};
    localparam logic [19:0] V_DECODE = {5'b00000, 2'b10, 2'b10, 2'b00, 5'b00000, 4'd1};
    localparam logic [19:0] V_MEMADR = {5'b00000, 2'b01, 2'b10, 2'b00, 5'b00000, 4'd2};
    localparam logic [19:0] V_MEMRD  = {5'b00101, 2'b00, 2'b00, 2'b00, 5'b00000, 4'd3};
    localparam logic [19:0] V_MEMWR  = {5'b00011, 2'b00, 2'b00, 2'b00, 5'b00010, 4'd4};
    localparam logic [19:0] V_LDWB   = {5'b00000, 2'b00, 2'b00, 2'b00, 5'b01110, 4'd5};
    localparam logic [19:0] V_EXECR  = {5'b00000, 2'b01, 2'b00, 2'b10, 5'b00000, 4'd6};
    localparam logic [19:0] V_RWB    = {5'b00000, 2'b00, 2'b00, 2'b00, 5'b01010, 4'd7};
    localparam logic [19:0] V_BR_T   = {5'b10000, 2'b01, 2'b00, 2'b01, 5'b10010, 4'd8};
    localparam logic [19:0] V_BR_NT  = {5'b00000, 2'b01, 2'b00, 2'b01, 5'b10010, 4'd8};
    localparam logic [19:0] V_HALT   = {5'b00000, 2'b00, 2'b00, 2'b00, 5'b00001, 4'd9};
    localparam logic [19:0] V_FWAIT  = {5'b00100, 2'b00, 2'b01, 2'b00, 5'b00000, 4'd0};

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
        .mem_ready     (mem_ready),
`endif
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .instr_retired (instr_retired),
        .halted        (halted),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retire pulses observed at each clock edge.
    always @(posedge clk) begin
        if (instr_retired) retire_cnt <= retire_cnt + 1;
    end

    task automatic check_vec(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check the current cycle (called just after a falling edge), then advance one cycle.
    task automatic cyc(input string tag, input logic [19:0] exp);
        #1;
        check_vec(tag, obs_vec, exp);
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 7'd0;
        zero   = 1'b0;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_vec("reset_state", obs_vec, V_ZERO);
        @(negedge clk);

        // Load: 5 cycles
        reset  = 1'b0;
        opcode = 7'b0000011;
        snap = retire_cnt;
        cyc("ld_fetch",  V_FETCH);
        cyc("ld_decode", V_DECODE);
        cyc("ld_memadr", V_MEMADR);
        cyc("ld_memrd",  V_MEMRD);
        cyc("ld_ldwb",   V_LDWB);
        check_int("ld_retires", retire_cnt - snap, 1);

        // Store then R-type back to back
        opcode = 7'b0100011;
        snap = retire_cnt;
        cyc("st_fetch",  V_FETCH);
        cyc("st_decode", V_DECODE);
        cyc("st_memadr", V_MEMADR);
        cyc("st_memwr",  V_MEMWR);
        opcode = 7'b0110011;
        cyc("r_fetch",   V_FETCH);
        cyc("r_decode",  V_DECODE);
        cyc("r_execr",   V_EXECR);
        cyc("r_rwb",     V_RWB);
        check_int("st_r_retires", retire_cnt - snap, 2);

        // Branch taken, then not taken
        opcode = 7'b1100011;
        zero   = 1'b1;
        cyc("bt_fetch",  V_FETCH);
        cyc("bt_decode", V_DECODE);
        cyc("bt_branch", V_BR_T);
        zero   = 1'b0;
        cyc("bn_fetch",  V_FETCH);
        cyc("bn_decode", V_DECODE);
        cyc("bn_branch", V_BR_NT);

        // Unsupported opcode halts
        opcode = 7'b0010011;
        cyc("il_fetch",  V_FETCH);
        cyc("il_decode", V_DECODE);
        snap = retire_cnt;
        for (int i = 0; i < 20; i++) begin
            cyc("halt_hold", V_HALT);
        end
        check_int("halt_no_retire", retire_cnt - snap, 0);
        reset = 1'b1;
        #1;
        check_vec("halt_reset", obs_vec, V_ZERO);
        @(negedge clk);
        reset  = 1'b0;
        opcode = 7'b0000011;
        cyc("post_halt_fetch", V_FETCH);

        // Reset during MEMRD aborts the load
        cyc("ab_decode", V_DECODE);
        cyc("ab_memadr", V_MEMADR);
        #1;
        check_vec("ab_memrd", obs_vec, V_MEMRD);
        snap = retire_cnt;
        #2;
        reset = 1'b1;
        #1;
        check_vec("ab_reset_same_cycle", obs_vec, V_ZERO);
        @(negedge clk);
        #1;
        check_vec("ab_reset_held", obs_vec, V_ZERO);
        reset  = 1'b0;
        opcode = 7'b0110011;
        #1;
        check_vec("ab_fetch", obs_vec, V_FETCH);
        check_int("ab_no_retire", retire_cnt - snap, 0);
        @(negedge clk);
        cyc("ab_r_decode", V_DECODE);
        cyc("ab_r_execr",  V_EXECR);
        cyc("ab_r_rwb",    V_RWB);
        cyc("ab_r_fetch",  V_FETCH);

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
        // Fetch stalled 3 cycles: load takes 8 cycles
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        opcode    = 7'b0000011;
        mem_ready = 1'b0;
        snap = retire_cnt;
        cyc("hs_fwait0", V_FWAIT);
        cyc("hs_fwait1", V_FWAIT);
        cyc("hs_fwait2", V_FWAIT);
        mem_ready = 1'b1;
        cyc("hs_fetch",  V_FETCH);
        cyc("hs_decode", V_DECODE);
        cyc("hs_memadr", V_MEMADR);
        cyc("hs_memrd",  V_MEMRD);
        cyc("hs_ldwb",   V_LDWB);
        check_int("hs_retires", retire_cnt - snap, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
